// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte-stream framing constants.
package instr_mem_loader_pkg;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_HI = 3'd1,
      ST_HDR_LO = 3'd2,
      ST_LOAD   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port. The loader is
// the master; the host front end and the memory sit on the slave side.
interface instr_mem_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      input  byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Assembles four stream bytes into one big-endian word; word_full marks the
// transfer that supplies the last byte, with the complete word on 'word'.
module byte_word_packer
   import instr_mem_loader_pkg::*;
(
   input  logic        clk_CPU,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] part_q, part_d;

   // Byte index and the three leading bytes of the word in progress
   always_comb begin
      idx_d  = idx_q;
      part_d = part_q;
      if (clr) begin
         idx_d  = 2'd0;
         part_d = 24'd0;
      end else if (shift_en) begin
         idx_d  = idx_q + 2'd1;
         part_d = {part_q[15:0], byte_in};
      end else begin
         idx_d  = idx_q;
         part_d = part_q;
      end
   end

   // Packer state register
   always_ff @(posedge clk_CPU or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= 2'd0;
         part_q <= 24'd0;
      end else begin
         idx_q  <= idx_d;
         part_q <= part_d;
      end
   end

   assign word      = {part_q, byte_in};
   assign word_full = shift_en && !clr && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads instruction memory from a header-framed byte stream and holds the CPU
// until the program is in place.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk_CPU,
   input  logic              rst_n,
   input  logic              start,
   instr_mem_loader_if.master bus,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

   state_e            state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [ADDR_W-1:0] widx_q, widx_d;
   logic [ADDR_W:0]   wl_q, wl_d;
   logic [ADDR_W:0]   wl_inc_s;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              hold_q, hold_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              xfer_s;
   logic [15:0]       n_full_s;
   logic              pk_clr_s, pk_shift_s, pk_full_s;
   logic [31:0]       pk_word_s;

   assign xfer_s     = bus.byte_valid && ready_q;
   assign n_full_s   = {n_q[15:8], bus.byte_in};
   assign wl_inc_s   = wl_q + {{ADDR_W{1'b0}}, 1'b1};
   assign pk_clr_s   = xfer_s && (state_q == ST_HDR_LO);
   assign pk_shift_s = xfer_s && (state_q == ST_LOAD);

   byte_word_packer u_packer (
      .clk_CPU   (clk_CPU),
      .rst_n     (rst_n),
      .clr       (pk_clr_s),
      .shift_en  (pk_shift_s),
      .byte_in   (bus.byte_in),
      .word      (pk_word_s),
      .word_full (pk_full_s)
   );

   // Next-state logic; every output is derived from the next state so it is registered
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      widx_d  = widx_q;
      wl_d    = wl_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_HDR_HI;
            else       state_d = state_q;
         end
         ST_HDR_HI: begin
            if (xfer_s) begin
               n_d     = {bus.byte_in, 8'h00};
               state_d = ST_HDR_LO;
            end else begin
               state_d = state_q;
            end
         end
         ST_HDR_LO: begin
            if (xfer_s) begin
               n_d    = n_full_s;
               err_d  = 1'b0;
               wl_d   = '0;
               widx_d = '0;
               if (n_full_s == 16'd0) begin
                  state_d = ST_DONE;
               end else if ({1'b0, n_full_s} > DEPTH) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (pk_full_s) begin
               addr_d  = widx_q;
               wdata_d = DATA_W'(pk_word_s);
               state_d = ST_WRITE;
            end else begin
               state_d = state_q;
            end
         end
         ST_WRITE: begin
            widx_d = widx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            wl_d   = wl_inc_s;
            if (17'(wl_inc_s) == {1'b0, n_q}) state_d = ST_DONE;
            else                              state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_HDR_HI) || (state_d == ST_HDR_LO) || (state_d == ST_LOAD);
      we_d    = (state_d == ST_WRITE);
      done_d  = (state_d == ST_DONE);
      hold_d  = (state_d != ST_DONE);
   end

   // Loader state and output registers
   always_ff @(posedge clk_CPU or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         n_q     <= 16'd0;
         widx_q  <= '0;
         wl_q    <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         hold_q  <= 1'b1;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         widx_q  <= widx_d;
         wl_q    <= wl_d;
         err_q   <= err_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.byte_ready = ready_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign cpu_hold       = hold_q;
   assign done           = done_q;
   assign err            = err_q;
   assign words_loaded   = wl_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: streams are built in the bench and
// the expected memory writes are derived directly from the framing rules.
module tb_instr_mem_loader;
   import instr_mem_loader_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic            clk_CPU = 1'b0;
   logic            rst_n   = 1'b0;
   logic            start   = 1'b0;
   logic            cpu_hold, done, err;
   logic [ADDR_W:0] words_loaded;

   instr_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_CPU      (clk_CPU),
      .rst_n        (rst_n),
      .start        (start),
      .bus          (bus),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk_CPU = ~clk_CPU;

   int         vectors    = 0;
   int         miscompares = 0;
   int         we_pulses  = 0;
   int         ready_viol = 0;
   wr_t        got[$];
   wr_t        exp_q[$];
   logic [7:0] stream[$];
   bit         exp_err;
   int         exp_wl;

   // Capture every memory write; byte_ready must be low while mem_we is high
   always @(negedge clk_CPU) begin
      if (bus.mem_we === 1'b1) begin
         got.push_back({bus.mem_addr, bus.mem_wdata});
         we_pulses <= we_pulses + 1;
         if (bus.byte_ready !== 1'b0) ready_viol <= ready_viol + 1;
      end
   end

   // Reference: header gives N, then N big-endian words written at 0..N-1
   function automatic void build_model();
      int n;
      exp_q.delete();
      n       = int'(stream[0]) * 256 + int'(stream[1]);
      exp_err = (n > DEPTH);
      exp_wl  = exp_err ? 0 : n;
      if (!exp_err) begin
         for (int i = 0; i < n; i++) begin
            wr_t w;
            w.addr = ADDR_W'(i);
            w.data = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
            exp_q.push_back(w);
         end
      end
   endfunction

   task automatic make_stream(input int n);
      stream.delete();
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
   endtask

   // mode 0: valid always, 1: valid toggles, 2: random; start pulsed once at byte start_at
   task automatic send_stream(input int mode, input int start_at);
      int idx = 0;
      int cyc = 0;
      bit v;
      bit pulsed = 1'b0;
      while (idx < stream.size() && cyc < stream.size() * 6 + 100) begin
         @(negedge clk_CPU);
         cyc++;
         case (mode)
            0:       v = 1'b1;
            1:       v = cyc[0];
            default: v = 1'($urandom_range(0, 1));
         endcase
         if (!pulsed && idx == start_at) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end else begin
            start = 1'b0;
         end
         bus.byte_valid = v;
         bus.byte_in    = stream[idx];
         if (v && bus.byte_ready === 1'b1) idx++;
      end
      @(negedge clk_CPU);
      bus.byte_valid = 1'b0;
      start          = 1'b0;
      vectors++;
      if (idx != stream.size()) begin
         miscompares++;
         $display("FAIL stream_accept: bytes taken %0d, required %0d", idx, stream.size());
      end
   endtask

   // One complete load: start, stream, then compare against the model
   task automatic test_load(input string name, input int mode, input int start_at);
      int g0, r0, lat, exp_lat;
      build_model();
      g0 = got.size();
      r0 = ready_viol;
      @(negedge clk_CPU) start = 1'b1;
      @(negedge clk_CPU) start = 1'b0;
      vectors++;
      if (cpu_hold !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_start: hold=%b done=%b, required hold=1 done=0", name, cpu_hold, done);
      end
      send_stream(mode, start_at);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk_CPU);
         lat++;
      end
      exp_lat = (exp_q.size() == 0) ? 0 : 1;
      vectors++;
      if (done !== 1'b1 || lat != exp_lat) begin
         miscompares++;
         $display("FAIL %s_done: done=%b after %0d cycles, required done=1 after %0d", name, done, lat, exp_lat);
      end
      vectors++;
      if (got.size() - g0 != exp_q.size()) begin
         miscompares++;
         $display("FAIL %s_write_count: got %0d, required %0d", name, got.size() - g0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
         vectors++;
         if (got[g0+i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s_write[%0d]: addr %h data %h, required addr %h data %h", name, i,
                     got[g0+i].addr, got[g0+i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors++;
      if (cpu_hold !== 1'b0 || err !== exp_err || words_loaded !== (ADDR_W+1)'(exp_wl)) begin
         miscompares++;
         $display("FAIL %s_status: hold=%b err=%b words=%0d, required hold=0 err=%b words=%0d",
                  name, cpu_hold, err, words_loaded, exp_err, exp_wl);
      end
      vectors++;
      if (ready_viol != r0) begin
         miscompares++;
         $display("FAIL %s_ready_in_write: %0d violations, required 0", name, ready_viol - r0);
      end
   endtask

   task automatic test_reset();
      int w0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk_CPU);
      vectors++;
      if (cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          words_loaded !== '0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
         miscompares++;
         $display("FAIL reset_values: hold=%b ready=%b done=%b err=%b words=%0d we=%b addr=%h data=%h, required 1 0 0 0 0 0 0 0",
                  cpu_hold, bus.byte_ready, done, err, words_loaded, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      rst_n = 1'b1;
      w0 = we_pulses;
      repeat (20) @(negedge clk_CPU);
      vectors++;
      if (we_pulses != w0 || cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_quiet: we_pulses=%0d hold=%b ready=%b done=%b, required 0 1 0 0",
                  we_pulses - w0, cpu_hold, bus.byte_ready, done);
      end
   endtask

   task automatic test_basic();
      stream = '{8'h00, 8'h02, 8'h01, 8'h2A, 8'h40, 8'h20, 8'h00, 8'h85, 8'h30, 8'h22};
      test_load("basic", 0, -1);
   endtask

   task automatic test_throttled();
      stream = '{8'h00, 8'h02, 8'h01, 8'h2A, 8'h40, 8'h20, 8'h00, 8'h85, 8'h30, 8'h22};
      test_load("throttled", 1, -1);
   endtask

   task automatic test_zero();
      stream = '{8'h00, 8'h00};
      test_load("zero_words", 0, -1);
   endtask

   task automatic test_overflow();
      stream = '{8'h01, 8'h01};
      test_load("overflow", 0, -1);
   endtask

   task automatic test_restart();
      stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      test_load("restart", 0, -1);
   endtask

   task automatic test_start_mid_load();
      make_stream(2);
      test_load("start_mid_load", 0, 5);
   endtask

   task automatic test_full();
      make_stream(DEPTH);
      test_load("full_depth", 0, -1);
   endtask

   task automatic test_reset_mid();
      int g0;
      int w0;
      make_stream(2);
      build_model();
      g0 = got.size();
      @(negedge clk_CPU) start = 1'b1;
      @(negedge clk_CPU) start = 1'b0;
      stream = stream[0:7];
      send_stream(0, -1);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          words_loaded !== '0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_values: hold=%b ready=%b done=%b err=%b words=%0d we=%b addr=%h data=%h, required 1 0 0 0 0 0 0 0",
                  cpu_hold, bus.byte_ready, done, err, words_loaded, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      vectors++;
      if (got.size() - g0 != 1 || (got.size() > g0 && got[g0] !== exp_q[0])) begin
         miscompares++;
         $display("FAIL reset_mid_word0: %0d writes, required 1 write of %h", got.size() - g0, exp_q[0].data);
      end
      repeat (2) @(negedge clk_CPU);
      rst_n = 1'b1;
      w0 = we_pulses;
      repeat (10) @(negedge clk_CPU);
      vectors++;
      if (we_pulses != w0) begin
         miscompares++;
         $display("FAIL reset_mid_quiet: %0d writes, required 0", we_pulses - w0);
      end
      make_stream(3);
      test_load("after_reset", 2, -1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) begin
         make_stream(int'($urandom_range(1, 6)));
         test_load("random", int'($urandom_range(0, 2)), -1);
      end
   endtask

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      test_reset();
      test_basic();
      test_throttled();
      test_zero();
      test_overflow();
      test_restart();
      test_start_mid_load();
      test_full();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction-memory interface. The CPU's instruction memory is only ever read by the datapath; this block fills it from a byte stream at power-up through a dedicated write port, and holds the CPU until the program is loaded. It replaces bench-only memory preloading with a synthesizable path: a UART/host front end feeds bytes, and the loader assembles words and writes them.

Parameters:
ADDR_W, 8, word-address width of instruction memory (depth 2**ADDR_W words)
DATA_W, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk_CPU  input  1  CPU clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_W  word address for the write
mem_wdata  output  DATA_W  word to write
cpu_hold  output  1  1 = CPU stalled (PC frozen, register-bank writes blocked)
done  output  1  load finished, level, held until next start
err  output  1  header word count exceeded memory depth
words_loaded  output  ADDR_W+1  count of words written in the current load

Behaviour:
- One clock and one reset: clk_CPU; rst_n is asynchronous and active-low.
- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, err 0, words_loaded 0, internal counters 0.
- A byte transfer occurs on a rising edge where byte_valid and byte_ready are both 1. byte_in must be stable while byte_valid=1 and byte_ready=0. No transfer occurs when byte_ready=0.
- Stream format: 2-byte header N (word count, big-endian), then N×4 bytes. Each word is big-endian: the first byte lands in bits [31:24].
- States and transitions:
  - IDLE: byte_ready=0. start -> HDR_HI.
  - HDR_HI: byte_ready=1. A transfer latches N[15:8]; -> HDR_LO.
  - HDR_LO: byte_ready=1. A transfer latches N[7:0], clears err, and clears words_loaded.
    - If N==0 -> DONE.
    - If N > 2**ADDR_W: err=1 -> DONE, with no writes.
    - Otherwise -> LOAD.
  - LOAD: byte_ready=1. A 2-bit byte index shifts the byte into the assembly register. On the 4th transfer -> WRITE.
  - WRITE: exactly one cycle. byte_ready=0. mem_we=1, mem_addr=word index, mem_wdata=assembled word. The word index and words_loaded each increment. If words_loaded (after increment) equals N -> DONE, else -> LOAD.
  - DONE: byte_ready=0, done=1, cpu_hold=0. start -> HDR_HI, clearing done and raising cpu_hold the following cycle.
- cpu_hold=1 in every state except DONE. It also deasserts in DONE with err=1: the CPU runs whatever memory already contains; err flags the condition.
- Latency: mem_we asserts the cycle after the edge that accepts the 4th byte of a word. Minimum 5 cycles per word.
- start outside IDLE/DONE is ignored; a load cannot be restarted mid-stream.
- A stalled stream (byte_valid=0) holds all state indefinitely; there is no timeout.
- Word index wraps never: with N ≤ 2**ADDR_W, the last write is at address N-1.
- rst_n asserted mid-load: immediate return to reset values. Partially assembled words are discarded; words already written stay in memory.
- mem_addr and mem_wdata hold their last values outside WRITE. Only mem_we qualifies them.

Decomposition:
- Shared package: loader state encoding (IDLE, HDR_HI, HDR_LO, LOAD, WRITE, DONE), the header length constant (2 bytes), and BYTES_PER_WORD=4.
- One natural sub-module, byte_word_packer: 4-byte shift/assemble register with byte index and a word_full flag. The FSM, counters, and the memory port stay in instr_mem_loader.
- Instruction memory gains a synchronous write port (we/addr/wdata) alongside its existing read port. The CPU top gates its PC and register-bank writes with cpu_hold.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> cpu_hold=1, byte_ready=0, done=0, mem_we never pulses over 20 cycles without start.
- Basic load: start; bytes 00 02 | 01 2A 40 20 | 00 85 30 22 with byte_valid always 1 -> mem_we pulses twice: addr 0 data 0x012A4020, then addr 1 data 0x00853022. done=1, cpu_hold=0, words_loaded=2.
- Throttled stream: same stream with byte_valid toggled 1/0 every cycle -> identical writes and data; byte_ready=0 in the WRITE cycle; no byte is lost or duplicated.
- Boundaries: header 00 00 -> DONE two transfers after start with no mem_we, err=0. Header 01 01 with ADDR_W=8 (257 > 256) -> err=1, done=1, no mem_we. Header 01 00 -> 256 writes, last at addr 0xFF.
- Reset mid-operation: assert rst_n low after the 2nd byte of word 1 -> word 0 was written, no further mem_we, all outputs at reset values. A fresh load then completes correctly.
- Restart: after done, pulse start and send a 1-word stream DE AD BE EF -> cpu_hold rises the cycle after start, then addr 0 is written with 0xDEADBEEF and done=1. A start pulse mid-LOAD is ignored.
